// File: rtl/riscv_mtimer.sv
// riscv_mtimer: machine-level timer and software-interrupt source.
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and
// the msip bit behind a word-addressed register bus with a fixed one-cycle ack.
// Optional feature macro: RISCV_MTIMER_PRESCALE_EN enables a 16-bit tick
// prescaler so mtime advances once every PRESCALE clocks; without it mtime
// advances every clock.
module riscv_mtimer #(
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        timer_irq_o,
  output logic        software_irq_o,
  output logic [63:0] mtime_o
);

  // Word indices of the register map.
  localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_MSIP     = 3'd4;

  // An out-of-range divider would silently truncate in the 16-bit counter.
  if ((PRESCALE < 32'd1) || (PRESCALE > 32'd65535)) begin : g_prescale_range
    $error("riscv_mtimer: PRESCALE must be within 1..65535");
  end

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        msip_r;
  logic        ack_r;
  logic [31:0] rdata_r;
  logic        timer_irq_r;

  logic        wr_s;
  logic        rd_s;
  logic        mtime_wr_s;
  logic        tick_s;
  logic [63:0] mtime_next_s;
  logic [63:0] mtimecmp_next_s;
  logic        msip_next_s;
  logic [31:0] rdata_next_s;

  // Decode the bus strobe into read / write / mtime-write qualifiers.
  always_comb begin
    wr_s       = req_i & we_i;
    rd_s       = req_i & ~we_i;
    mtime_wr_s = wr_s & ((addr_i == ADDR_MTIME_LO) | (addr_i == ADDR_MTIME_HI));
  end

`ifdef RISCV_MTIMER_PRESCALE_EN
  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 32'd1);

  logic [15:0] presc_cnt_r;

  // A tick fires on the last count of each prescale period.
  always_comb begin
    tick_s = (presc_cnt_r == PRESCALE_LAST);
  end

  // Prescale counter: wraps after a tick and restarts on any mtime write so
  // the first tick after a write lands a full period later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt_r <= 16'd0;
    end else if (mtime_wr_s || tick_s) begin
      presc_cnt_r <= 16'd0;
    end else begin
      presc_cnt_r <= presc_cnt_r + 16'd1;
    end
  end
`else
  // Without the prescaler mtime advances on every clock.
  always_comb begin
    tick_s = 1'b1;
  end
`endif

  // Next mtime: a write to either half replaces that half and suppresses the
  // tick; otherwise a tick performs one 64-bit increment so the carry between
  // halves is never split across cycles.
  always_comb begin
    mtime_next_s = mtime_r;
    if (mtime_wr_s) begin
      case (addr_i)
        ADDR_MTIME_LO: mtime_next_s = {mtime_r[63:32], wdata_i};
        ADDR_MTIME_HI: mtime_next_s = {wdata_i, mtime_r[31:0]};
        default:       mtime_next_s = mtime_r;
      endcase
    end else if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
  end

  // Next mtimecmp and msip from bus writes; reserved addresses are ignored.
  always_comb begin
    mtimecmp_next_s = mtimecmp_r;
    msip_next_s     = msip_r;
    if (wr_s) begin
      case (addr_i)
        ADDR_CMP_LO: mtimecmp_next_s = {mtimecmp_r[63:32], wdata_i};
        ADDR_CMP_HI: mtimecmp_next_s = {wdata_i, mtimecmp_r[31:0]};
        ADDR_MSIP:   msip_next_s     = wdata_i[0];
        default: begin
          mtimecmp_next_s = mtimecmp_r;
          msip_next_s     = msip_r;
        end
      endcase
    end else begin
      mtimecmp_next_s = mtimecmp_r;
      msip_next_s     = msip_r;
    end
  end

  // Read mux over the pre-update register values; non-reads return zero.
  always_comb begin
    rdata_next_s = 32'd0;
    if (rd_s) begin
      case (addr_i)
        ADDR_MTIME_LO: rdata_next_s = mtime_r[31:0];
        ADDR_MTIME_HI: rdata_next_s = mtime_r[63:32];
        ADDR_CMP_LO:   rdata_next_s = mtimecmp_r[31:0];
        ADDR_CMP_HI:   rdata_next_s = mtimecmp_r[63:32];
        ADDR_MSIP:     rdata_next_s = {31'd0, msip_r};
        default:       rdata_next_s = 32'd0;
      endcase
    end else begin
      rdata_next_s = 32'd0;
    end
  end

  // Timer state and the interrupt level, compared on post-update values so a
  // compare write is reflected on the very next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_r     <= 64'd0;
      mtimecmp_r  <= MTIMECMP_RST;
      msip_r      <= 1'b0;
      timer_irq_r <= 1'b0;
    end else begin
      mtime_r     <= mtime_next_s;
      mtimecmp_r  <= mtimecmp_next_s;
      msip_r      <= msip_next_s;
      timer_irq_r <= (mtime_next_s >= mtimecmp_next_s);
    end
  end

  // Bus response: every request is acked exactly one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r   <= req_i;
      rdata_r <= rdata_next_s;
    end
  end

  assign rdata_o        = rdata_r;
  assign ack_o          = ack_r;
  assign timer_irq_o    = timer_irq_r;
  assign software_irq_o = msip_r;
  assign mtime_o        = mtime_r;

endmodule
